// File: rtl/hififo_pkg.sv
// -----------------------------------------------------------------------------
// hififo_pkg
// Shared constants for the block-RAM backed FIFO controller, plus a helper that
// counts the reads currently travelling through the RAM read pipeline.
// -----------------------------------------------------------------------------
package hififo_pkg;

    localparam int DEFAULT_ABITS   = 9;
    localparam int DEFAULT_DBITS   = 64;
    localparam int BRAM_RD_LATENCY = 2;
    localparam int PREFETCH_DEPTH  = 4;

    // Width able to hold 0..BRAM_RD_LATENCY outstanding reads
    localparam int INFLIGHT_CW = $clog2(BRAM_RD_LATENCY + 1);

    // One bit per RAM read pipeline stage; MSB means r_data is valid now
    typedef logic [BRAM_RD_LATENCY-1:0] inflight_t;

    function automatic logic [INFLIGHT_CW-1:0] inflight_count(input inflight_t v);
        logic [INFLIGHT_CW-1:0] n;
        n = '0;
        for (int i = 0; i < BRAM_RD_LATENCY; i++) begin
            n = n + INFLIGHT_CW'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// -----------------------------------------------------------------------------
// fifo_prefetch_buf
// Small circular buffer that holds words returned by the block RAM until the
// consumer takes them. Head word is presented combinationally.
//   clock    in   sole clock
//   reset_n  in   asynchronous active-low reset, empties the buffer
//   i_push   in   write i_data at the tail (caller guarantees room)
//   i_data   in   word to store
//   i_pop    in   drop the head word (ignored when empty)
//   o_data   out  head word
//   o_count  out  number of words held
// -----------------------------------------------------------------------------
module fifo_prefetch_buf #(
    parameter  int DEPTH = 4,
    parameter  int DBITS = 64,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [DBITS-1:0] i_data,
    input  logic             i_pop,
    output logic [DBITS-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    logic [DBITS-1:0] r_mem [DEPTH];
    logic [IW-1:0]    r_wr_idx;
    logic [IW-1:0]    r_rd_idx;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd_idx];
    assign o_count = r_count;

    // Tail write: store the pushed word and advance the tail index
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_idx <= '0;
        end else if (i_push) begin
            r_mem[r_wr_idx] <= i_data;
            r_wr_idx        <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IW'(1);
        end
    end

    // Head advance on pop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_idx <= '0;
        end else if (w_pop) begin
            r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IW'(1);
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// bram_fifo_ctrl
// FIFO controller around an external dual-port block RAM whose write port is
// registered (a write lands in the array one edge after it is presented) and
// whose read data appears BRAM_RD_LATENCY clocks after r_addr is sampled.
// Reads are prefetched into a small output buffer so both sides run at one
// word per clock.
//   clock, reset_n            clock and asynchronous active-low reset
//   i_data/i_valid/i_ready    write side (ready/valid)
//   o_data/o_valid/o_ready    read side (ready/valid), head of prefetch buffer
//   count                     words held: RAM + reads in flight + buffer
//   ram_w_data/valid/addr     block RAM write port
//   ram_r_addr/ram_r_data     block RAM read port
// -----------------------------------------------------------------------------
module bram_fifo_ctrl
    import hififo_pkg::*;
#(
    parameter int ABITS     = DEFAULT_ABITS,
    parameter int DBITS     = DEFAULT_DBITS,
    parameter int BUF_DEPTH = PREFETCH_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [DBITS-1:0] i_data,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [DBITS-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [ABITS+1:0] count,
    output logic [DBITS-1:0] ram_w_data,
    output logic             ram_w_valid,
    output logic [ABITS-1:0] ram_w_addr,
    output logic [ABITS-1:0] ram_r_addr,
    input  logic [DBITS-1:0] ram_r_data
);

    localparam int PW  = ABITS + 1;
    localparam int CW  = ABITS + 2;
    localparam int BCW = $clog2(BUF_DEPTH + 1);
    localparam int OW  = BCW + INFLIGHT_CW;

    localparam logic [PW-1:0] RAM_FULL     = {1'b1, {ABITS{1'b0}}};
    localparam logic [OW-1:0] CREDIT_LIMIT = OW'(BUF_DEPTH);

    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_wr_ptr_vis;   // write pointer whose words have landed in the array
    logic [PW-1:0]  r_rd_ptr;
    inflight_t      r_inflight;

    logic [PW-1:0]  w_ram_used;
    logic           w_wr_en;
    logic           w_rd_en;
    logic           w_pop;
    logic           w_ram_rvalid;
    logic [BCW-1:0] w_buf_count;
    logic [OW-1:0]  w_outstanding;

    assign w_ram_used = r_wr_ptr - r_rd_ptr;
    assign i_ready    = (w_ram_used != RAM_FULL);
    assign w_wr_en    = i_valid && i_ready;

    // Buffer slots already promised: held words plus reads still in the RAM.
    // A pop in this same cycle is deliberately not credited.
    assign w_outstanding = OW'(w_buf_count) + OW'(inflight_count(r_inflight));

    // Only read words whose RAM write has already landed, so the read address
    // is never sampled on the same edge the array is being written.
    assign w_rd_en = (r_rd_ptr != r_wr_ptr_vis) && (w_outstanding < CREDIT_LIMIT);

    assign w_ram_rvalid = r_inflight[BRAM_RD_LATENCY-1];
    assign o_valid      = (w_buf_count != '0);
    assign w_pop        = o_valid && o_ready;

    assign ram_w_data  = i_data;
    assign ram_w_valid = w_wr_en;
    assign ram_w_addr  = r_wr_ptr[ABITS-1:0];
    assign ram_r_addr  = r_rd_ptr[ABITS-1:0];

    assign count = CW'(w_ram_used) + CW'(inflight_count(r_inflight)) + CW'(w_buf_count);

    // Write pointer and its one-edge-delayed copy (tracks the registered RAM write port)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_wr_ptr_vis <= '0;
        end else begin
            r_wr_ptr_vis <= r_wr_ptr;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
        end
    end

    // Read pointer advances on every read issued to the RAM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
        end else if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // In-flight tracker mirrors the RAM read latency; clearing it on reset
    // discards any read data still on its way out of the RAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= {r_inflight[BRAM_RD_LATENCY-2:0], w_rd_en};
        end
    end

    fifo_prefetch_buf #(
        .DEPTH (BUF_DEPTH),
        .DBITS (DBITS)
    ) u_prefetch_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_ram_rvalid),
        .i_data  (ram_r_data),
        .i_pop   (w_pop),
        .o_data  (o_data),
        .o_count (w_buf_count)
    );

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_fifo_ctrl
// Bench for bram_fifo_ctrl with ABITS=4 and a behavioural block RAM (registered
// write port, two-stage read pipeline). A queue holds every accepted word in
// order; count must equal its size and o_data must equal its head.
// -----------------------------------------------------------------------------
module tb_bram_fifo_ctrl;

    localparam int ABITS = 4;
    localparam int DBITS = 16;
    localparam int CW    = ABITS + 2;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic [DBITS-1:0] i_data  = '0;
    logic             i_valid = 1'b0;
    logic             i_ready;
    logic [DBITS-1:0] o_data;
    logic             o_valid;
    logic             o_ready = 1'b0;
    logic [CW-1:0]    count;
    logic [DBITS-1:0] ram_w_data;
    logic             ram_w_valid;
    logic [ABITS-1:0] ram_w_addr;
    logic [ABITS-1:0] ram_r_addr;
    logic [DBITS-1:0] ram_r_data;

    always #5 clock = ~clock;

    bram_fifo_ctrl #(
        .ABITS     (ABITS),
        .DBITS     (DBITS),
        .BUF_DEPTH (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .count       (count),
        .ram_w_data  (ram_w_data),
        .ram_w_valid (ram_w_valid),
        .ram_w_addr  (ram_w_addr),
        .ram_r_addr  (ram_r_addr),
        .ram_r_data  (ram_r_data)
    );

    // Block RAM model: write lands one edge after presentation, read data two clocks after address
    logic [DBITS-1:0] ram_mem [16];
    logic             ram_wv_q;
    logic [ABITS-1:0] ram_wa_q;
    logic [DBITS-1:0] ram_wd_q;
    logic [DBITS-1:0] ram_p1;
    logic [DBITS-1:0] ram_p2;

    always @(posedge clock) begin
        if (ram_wv_q) ram_mem[ram_wa_q] <= ram_wd_q;
        ram_wv_q <= ram_w_valid;
        ram_wa_q <= ram_w_addr;
        ram_wd_q <= ram_w_data;
        ram_p1   <= ram_mem[ram_r_addr];
        ram_p2   <= ram_p1;
    end
    assign ram_r_data = ram_p2;

    int n_checks = 0;
    int n_errors = 0;
    logic [DBITS-1:0] model_q [$];
    logic last_acc;
    logic last_pop;

    typedef struct {
        logic             iv;
        logic [DBITS-1:0] din;
        logic             ordy;
        logic             ov;
        logic             chk_d;
        logic [DBITS-1:0] dout;
        logic [CW-1:0]    cnt;
        logic             ir;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare outputs against the queue model, record handshakes, advance one clock
    task automatic sb_cycle();
        check("count_vs_model", 32'(count), 32'(model_q.size()));
        if (model_q.size() == 0) begin
            check("o_valid_when_empty", 32'(o_valid), 32'd0);
        end else if (o_valid) begin
            check("o_data_order", 32'(o_data), 32'(model_q[0]));
        end
        if (model_q.size() < 16) check("i_ready_room", 32'(i_ready), 32'd1);
        if (model_q.size() >= 20) check("i_ready_full", 32'(i_ready), 32'd0);
        last_acc = i_valid && i_ready;
        last_pop = o_valid && o_ready;
        if (last_pop && model_q.size() != 0) void'(model_q.pop_front());
        if (last_acc) model_q.push_back(i_data);
        @(negedge clock);
    endtask

    initial begin
        int sent;
        int n_pop;
        int n_acc;
        int ir_back;
        int w;
        int n_out;
        bit seen_valid;

        // Single word into an empty FIFO: accepted at edge 0, visible after edge 4
        vecs[0] = '{1'b1, 16'h00A5, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd0, 1'b1};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd1, 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd1, 1'b1};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd1, 1'b1};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd1, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00A5, 6'd1, 1'b1};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd0, 1'b1};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd0, 1'b1};

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("reset_o_valid", 32'(o_valid), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_i_ready", 32'(i_ready), 32'd1);
        check("reset_ram_w_valid", 32'(ram_w_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            i_valid = vecs[k].iv;
            i_data  = vecs[k].din;
            o_ready = vecs[k].ordy;
            #1;
            check($sformatf("vec%0d_o_valid", k), 32'(o_valid), 32'(vecs[k].ov));
            if (vecs[k].chk_d) check($sformatf("vec%0d_o_data", k), 32'(o_data), 32'(vecs[k].dout));
            check($sformatf("vec%0d_count", k), 32'(count), 32'(vecs[k].cnt));
            check($sformatf("vec%0d_i_ready", k), 32'(i_ready), 32'(vecs[k].ir));
            @(negedge clock);
        end

        // Stream 100 incrementing words at full rate on both sides
        sent = 0;
        n_pop = 0;
        seen_valid = 1'b0;
        for (int cyc = 0; cyc < 400 && n_pop < 100; cyc++) begin
            i_valid = (sent < 100);
            i_data  = 16'(16'h1000 + sent);
            o_ready = 1'b1;
            #1;
            if (seen_valid) check("stream_o_valid_continuous", 32'(o_valid), 32'd1);
            if (n_pop >= 1 && sent < 100)
                check("stream_count_4_or_5", 32'(count == 6'd4 || count == 6'd5), 32'd1);
            if (o_valid) seen_valid = 1'b1;
            sb_cycle();
            if (last_acc) sent++;
            if (last_pop) n_pop++;
        end
        check("stream_words_out", 32'(n_pop), 32'd100);

        // Fill with the consumer stalled: 16 in RAM plus 4 prefetched
        n_acc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            i_valid = 1'b1;
            i_data  = 16'(16'h2000 + n_acc);
            o_ready = 1'b0;
            #1;
            sb_cycle();
            if (last_acc) n_acc++;
        end
        #1;
        check("fill_accepts", 32'(n_acc), 32'd20);
        check("fill_count", 32'(count), 32'd20);
        check("fill_i_ready", 32'(i_ready), 32'd0);
        check("fill_o_valid", 32'(o_valid), 32'd1);

        // Write offered while full and a pop happens: the pop frees the buffer, not the RAM
        i_valid = 1'b1;
        i_data  = 16'hDEAD;
        o_ready = 1'b1;
        #1;
        check("full_pop_i_ready", 32'(i_ready), 32'd0);
        sb_cycle();

        // Drain; i_ready returns once the freed buffer slot triggers a RAM read
        i_valid = 1'b0;
        ir_back = -1;
        for (int cyc = 0; cyc < 60 && model_q.size() != 0; cyc++) begin
            #1;
            if (ir_back < 0 && i_ready) ir_back = cyc;
            sb_cycle();
        end
        check("drain_empty", 32'(model_q.size()), 32'd0);
        check("i_ready_return_cycle", 32'(ir_back), 32'd1);

        // Pointer wrap: three 16-word fill/drain rounds with random handshakes
        for (int r = 0; r < 3; r++) begin
            w = 0;
            for (int cyc = 0; cyc < 400 && w < 16; cyc++) begin
                i_valid = 1'($urandom_range(0, 1));
                i_data  = 16'($urandom);
                o_ready = 1'($urandom_range(0, 1));
                #1;
                sb_cycle();
                if (last_acc) w++;
            end
            check("wrap_writes", 32'(w), 32'd16);
            i_valid = 1'b0;
            for (int cyc = 0; cyc < 400 && model_q.size() != 0; cyc++) begin
                o_ready = 1'($urandom_range(0, 1));
                #1;
                sb_cycle();
            end
            #1;
            check("wrap_drained", 32'(model_q.size()), 32'd0);
            check("wrap_count_zero", 32'(count), 32'd0);
        end

        // Reset with two reads in flight: everything is discarded immediately
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 16'h0AAA;
        #1;
        sb_cycle();
        i_data = 16'h0BBB;
        sb_cycle();
        i_valid = 1'b0;
        sb_cycle();
        sb_cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_o_valid", 32'(o_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        model_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        i_valid = 1'b1;
        i_data  = 16'h1234;
        o_ready = 1'b1;
        #1;
        sb_cycle();
        i_valid = 1'b0;
        n_out = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (o_valid) check("post_reset_data", 32'(o_data), 32'h1234);
            sb_cycle();
            if (last_pop) n_out++;
        end
        check("post_reset_outputs", 32'(n_out), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
